// File: rtl/trig_pkg.sv
// Shared types and constants for the trigger capture controller.
package trig_pkg;

  localparam int unsigned DEF_ENTRIES = 384;

  localparam int unsigned TRIG_UART = 0;
  localparam int unsigned TRIG_EXT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMING,
    ST_WAIT_TRIG,
    ST_POST,
    ST_DONE
  } cap_state_t;

endpackage

// File: rtl/cap_addr_cnt.sv
// Modulo-ENTRIES write-address counter for the circular capture RAM.
module cap_addr_cnt #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned ADDR_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);

  // Clear takes priority over increment; wrap from LAST back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= (addr == LAST) ? '0 : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/trig_capture.sv
// Capture controller: fills the pre-trigger region, accepts a qualified
// trigger once armed, counts post-trigger samples and flags completion.
module trig_capture
  import trig_pkg::*;
#(
  parameter int unsigned ENTRIES = DEF_ENTRIES,
  parameter int unsigned ADDR_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              UARTtrig,
  input  logic              ext_trig,
  input  logic [1:0]        trig_src,
  input  logic              start,
  input  logic              clr_done,
  input  logic              smpl_en,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int unsigned       CNT_W  = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] TP_MAX = ADDR_W'(ENTRIES - 1);

  cap_state_t        state, state_nxt;
  logic [ADDR_W-1:0] tp_q, tp_nxt, tp_clamp;
  logic [CNT_W-1:0]  pre_cnt, pre_nxt, pre_inc, pre_target;
  logic [CNT_W-1:0]  post_cnt, post_nxt, post_inc;
  logic              armed_nxt, triggered_nxt, done_nxt;
  logic [ADDR_W-1:0] trig_addr_nxt;
  logic              addr_clr;
  logic              trig_hit;

  assign trig_hit = (trig_src[TRIG_UART] & UARTtrig) | (trig_src[TRIG_EXT] & ext_trig);

  // Post-trigger length is forced into 1..ENTRIES-1 so both regions are non-empty.
  always_comb begin
    tp_clamp = trig_pos;
    if (trig_pos == '0) begin
      tp_clamp = ADDR_W'(1);
    end else if ({1'b0, trig_pos} >= CNT_W'(ENTRIES)) begin
      tp_clamp = TP_MAX;
    end
  end

  assign pre_target = CNT_W'(ENTRIES) - {1'b0, tp_q};
  assign pre_inc    = pre_cnt + CNT_W'(1);
  assign post_inc   = post_cnt + CNT_W'(1);

  cap_addr_cnt #(
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W)
  ) u_addr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (addr_clr),
    .inc   (we),
    .addr  (waddr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      tp_q         <= ADDR_W'(1);
      pre_cnt      <= '0;
      post_cnt     <= '0;
      armed        <= 1'b0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
      trig_addr    <= '0;
    end else begin
      state        <= state_nxt;
      tp_q         <= tp_nxt;
      pre_cnt      <= pre_nxt;
      post_cnt     <= post_nxt;
      armed        <= armed_nxt;
      triggered    <= triggered_nxt;
      capture_done <= done_nxt;
      trig_addr    <= trig_addr_nxt;
    end
  end

  // Next-state, counter and flag logic; we is the only combinational output.
  always_comb begin
    state_nxt     = state;
    tp_nxt        = tp_q;
    pre_nxt       = pre_cnt;
    post_nxt      = post_cnt;
    armed_nxt     = armed;
    triggered_nxt = triggered;
    done_nxt      = capture_done;
    trig_addr_nxt = trig_addr;
    addr_clr      = 1'b0;
    we            = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          tp_nxt        = tp_clamp;
          pre_nxt       = '0;
          post_nxt      = '0;
          trig_addr_nxt = '0;
          addr_clr      = 1'b1;
          state_nxt     = ST_ARMING;
        end
      end
      ST_ARMING: begin
        we = smpl_en;
        if (smpl_en) begin
          pre_nxt = pre_inc;
          if (pre_inc == pre_target) begin
            armed_nxt = 1'b1;
            state_nxt = ST_WAIT_TRIG;
          end
        end
      end
      ST_WAIT_TRIG: begin
        we = smpl_en;
        if (trig_hit) begin
          trig_addr_nxt = waddr;
          triggered_nxt = 1'b1;
          // A write in the trigger cycle is already post-sample #1.
          if (tp_q == ADDR_W'(1) && smpl_en) begin
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            post_nxt  = CNT_W'(smpl_en);
            state_nxt = ST_POST;
          end
        end
      end
      ST_POST: begin
        we = smpl_en;
        if (smpl_en) begin
          post_nxt = post_inc;
          if (post_inc == {1'b0, tp_q}) begin
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (clr_done) begin
          armed_nxt     = 1'b0;
          triggered_nxt = 1'b0;
          done_nxt      = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trig_capture.sv
// Randomized self-checking bench for trig_capture against a write-count model.
module tb_trig_capture;

  localparam int unsigned ENTRIES = 384;
  localparam int unsigned ADDR_W  = 9;

  logic              clk;
  logic              rst_n;
  logic              UARTtrig;
  logic              ext_trig;
  logic [1:0]        trig_src;
  logic              start;
  logic              clr_done;
  logic              smpl_en;
  logic [ADDR_W-1:0] trig_pos;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              armed;
  logic              triggered;
  logic              capture_done;
  logic [ADDR_W-1:0] trig_addr;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: progress expressed as sample counts since start.
  bit                m_idle;
  bit                m_armed;
  bit                m_trig;
  bit                m_done;
  int                m_writes;
  int                m_post;
  int                m_tp;
  logic [ADDR_W-1:0] m_taddr;

  trig_capture #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .UARTtrig     (UARTtrig),
    .ext_trig     (ext_trig),
    .trig_src     (trig_src),
    .start        (start),
    .clr_done     (clr_done),
    .smpl_en      (smpl_en),
    .trig_pos     (trig_pos),
    .we           (we),
    .waddr        (waddr),
    .armed        (armed),
    .triggered    (triggered),
    .capture_done (capture_done),
    .trig_addr    (trig_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampf(input int t);
    if (t == 0) return 1;
    if (t >= int'(ENTRIES)) return int'(ENTRIES) - 1;
    return t;
  endfunction

  function automatic void model_reset();
    m_idle   = 1'b1;
    m_armed  = 1'b0;
    m_trig   = 1'b0;
    m_done   = 1'b0;
    m_writes = 0;
    m_post   = 0;
    m_tp     = 1;
    m_taddr  = '0;
  endfunction

  // One clock: check registered outputs, drive inputs, check we, advance model.
  task automatic cyc(input logic s, input logic u, input logic e, input logic st, input logic cl);
    logic hit;
    logic we_e;
    @(negedge clk);
    n_cmp++;
    if ({armed, triggered, capture_done} !== {m_armed, m_trig, m_done}) begin
      n_bad++;
      $display("FAIL flags: got a/t/d=%b%b%b expected %b%b%b at %0t",
               armed, triggered, capture_done, m_armed, m_trig, m_done, $time);
    end
    n_cmp++;
    if (waddr !== ADDR_W'(m_writes % ENTRIES)) begin
      n_bad++;
      $display("FAIL waddr: got %0d expected %0d at %0t", waddr, m_writes % ENTRIES, $time);
    end
    if (m_trig) begin
      n_cmp++;
      if (trig_addr !== m_taddr) begin
        n_bad++;
        $display("FAIL trig_addr: got %0d expected %0d at %0t", trig_addr, m_taddr, $time);
      end
    end
    smpl_en  = s;
    UARTtrig = u;
    ext_trig = e;
    start    = st;
    clr_done = cl;
    #1;
    hit  = (trig_src[0] & u) | (trig_src[1] & e);
    we_e = s & !m_idle & !m_done;
    n_cmp++;
    if (we !== we_e) begin
      n_bad++;
      $display("FAIL we: got %b expected %b at %0t", we, we_e, $time);
    end
    if (m_idle) begin
      if (st) begin
        m_idle   = 1'b0;
        m_writes = 0;
        m_post   = 0;
        m_tp     = clampf(int'(trig_pos));
      end
    end else if (m_done) begin
      if (cl) begin
        m_idle  = 1'b1;
        m_done  = 1'b0;
        m_armed = 1'b0;
        m_trig  = 1'b0;
      end
    end else begin
      if (m_armed && !m_trig && hit) begin
        m_trig  = 1'b1;
        m_taddr = ADDR_W'(m_writes % ENTRIES);
        m_post  = 0;
      end
      if (we_e) begin
        m_writes++;
        if (m_trig) begin
          m_post++;
          if (m_post == m_tp) m_done = 1'b1;
        end else if (!m_armed && m_writes == int'(ENTRIES) - m_tp) begin
          m_armed = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; smpl_en = 1'b1; UARTtrig = 1'b0; ext_trig = 1'b0;
    start = 1'b0; clr_done = 1'b0;
    #1;
    n_cmp++;
    if ({we, armed, triggered, capture_done} !== 4'b0 || waddr !== '0 || trig_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we/a/t/d=%b%b%b%b waddr=%0d taddr=%0d expected all 0",
               we, armed, triggered, capture_done, waddr, trig_addr);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive continuous samples until armed shows up; returns writes issued.
  task automatic arm_count(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
      @(posedge clk); #1;
      if (armed) break;
    end
    if (!armed) begin
      n_bad++;
      $display("FAIL arm_timeout: armed got 0 expected 1 after %0d writes", n);
    end
  endtask

  task automatic finish_cap();
    for (int i = 0; i < 1000 && !m_done; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (!m_done) begin
      n_bad++;
      $display("FAIL done_timeout: model did not complete");
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_cap(input logic [ADDR_W-1:0] tp, input logic [1:0] src, input int unsigned pct);
    trig_src = src;
    trig_pos = tp;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4000 && !m_done; i++)
      cyc(logic'($urandom_range(99) < pct), logic'($urandom_range(7) == 0),
          logic'($urandom_range(7) == 0), 1'b0, 1'b0);
    n_cmp++;
    if (!m_done) begin
      n_bad++;
      $display("FAIL run_timeout: done got 0 expected 1 (tp=%0d)", tp);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    trig_src = 2'b01;
    trig_pos = '0;
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_basic();
    int n;
    trig_src = 2'b01;
    trig_pos = ADDR_W'(100);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    arm_count(n);
    n_cmp++;
    if (n !== 284) begin
      n_bad++;
      $display("FAIL basic_arm_writes: got %0d expected 284", n);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (!triggered || trig_addr !== ADDR_W'(284)) begin
      n_bad++;
      $display("FAIL basic_trig_addr: got trig=%b addr=%0d expected 1/284", triggered, trig_addr);
    end
    n = 1;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
      @(posedge clk); #1;
      if (capture_done) break;
    end
    n_cmp++;
    if (!capture_done || n !== 100 || waddr !== '0) begin
      n_bad++;
      $display("FAIL basic_done: got done=%b posts=%0d waddr=%0d expected 1/100/0",
               capture_done, n, waddr);
    end
  endtask

  task automatic test_done_cmds();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (!capture_done || waddr !== '0) begin
      n_bad++;
      $display("FAIL done_start_ignored: got done=%b waddr=%0d expected 1/0", capture_done, waddr);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if ({armed, triggered, capture_done} !== 3'b000) begin
      n_bad++;
      $display("FAIL clr_wins: got a/t/d=%b%b%b expected 000", armed, triggered, capture_done);
    end
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cap(ADDR_W'(20), 2'b11, 70);
  endtask

  task automatic test_ignore();
    trig_src = 2'b01;
    trig_pos = ADDR_W'(300);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1000 && !m_armed; i++)
      cyc(logic'($urandom_range(1)), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (!armed || triggered) begin
      n_bad++;
      $display("FAIL masked_trig: got armed=%b trig=%b expected 1/0", armed, triggered);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (!triggered) begin
      n_bad++;
      $display("FAIL later_uart: got trig=%b expected 1", triggered);
    end
    finish_cap();
  endtask

  task automatic test_tp1();
    int k;
    int strobes;
    logic s;
    trig_src = 2'b10;
    trig_pos = ADDR_W'(1);
    k = 0;
    for (int pass = 0; pass < 2; pass++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      k = 1;
      for (int i = 0; i < 3000 && !m_armed; i++) begin
        cyc(logic'(k % 4 == 0), 1'b0, 1'b0, 1'b0, 1'b0);
        k++;
      end
      while (k % 4 != pass) begin
        cyc(logic'(k % 4 == 0), 1'b0, 1'b0, 1'b0, 1'b0);
        k++;
      end
      cyc(logic'(k % 4 == 0), 1'b0, 1'b1, 1'b0, 1'b0);
      k++;
      @(posedge clk); #1;
      n_cmp++;
      if (pass == 0) begin
        if (!capture_done || !triggered || waddr !== ADDR_W'((int'(trig_addr) + 1) % ENTRIES)) begin
          n_bad++;
          $display("FAIL tp1_hit_with_strobe: got done=%b trig=%b waddr=%0d taddr=%0d expected done, waddr=taddr+1",
                   capture_done, triggered, waddr, trig_addr);
        end
      end else begin
        if (capture_done || !triggered) begin
          n_bad++;
          $display("FAIL tp1_hit_no_strobe: got done=%b trig=%b expected 0/1", capture_done, triggered);
        end
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
          s = logic'(k % 4 == 0);
          cyc(s, 1'b0, 1'b0, 1'b0, 1'b0);
          k++;
          if (s) strobes++;
          @(posedge clk); #1;
          if (capture_done) break;
        end
        n_cmp++;
        if (!capture_done || strobes !== 1) begin
          n_bad++;
          $display("FAIL tp1_post_strobe: got done=%b strobes=%0d expected 1/1", capture_done, strobes);
        end
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      k++;
    end
  endtask

  task automatic test_reset_mid();
    trig_src = 2'b01;
    trig_pos = ADDR_W'(50);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 400 && !m_armed; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clamp();
    int n;
    trig_src = 2'b01;
    trig_pos = '0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    arm_count(n);
    n_cmp++;
    if (n !== 383) begin
      n_bad++;
      $display("FAIL clamp_zero_arm: got %0d writes expected 383", n);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (!capture_done) begin
      n_bad++;
      $display("FAIL clamp_zero_done: got done=%b expected 1", capture_done);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    trig_pos = ADDR_W'(384);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    arm_count(n);
    n_cmp++;
    if (n !== 1) begin
      n_bad++;
      $display("FAIL clamp_max_arm: got %0d writes expected 1", n);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    finish_cap();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++)
      run_cap(ADDR_W'($urandom_range(383, 1)), 2'($urandom_range(3, 1)),
              int'($urandom_range(100, 40)));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_cmds();
    test_ignore();
    test_tp1();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trig_capture.md
# trig_capture

Capture controller sitting directly downstream of the protocol triggers (UART one-cycle match pulse plus one generic external trigger pulse). It gates sample writes into the circular capture RAM, fills a pre-trigger region, accepts a qualified trigger once armed, counts post-trigger samples, and raises a sticky done flag for the host command path. It also reports the RAM address at which the trigger landed, so readback can be unrolled.

## Interface
- ENTRIES, 384: capture RAM depth in samples
- ADDR_W, 9: address width, $clog2(ENTRIES)

- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- UARTtrig  in  1  one-cycle match pulse from UART protocol trigger
- ext_trig  in  1  one-cycle pulse from other trigger sources
- trig_src  in  2  [0] enables UARTtrig, [1] enables ext_trig; 2'b00 = never trigger
- start  in  1  one-cycle capture request from command path
- clr_done  in  1  one-cycle host acknowledge; clears done and returns to idle
- smpl_en  in  1  sample strobe from decimator; one sample per high cycle
- trig_pos  in  ADDR_W  post-trigger sample count; latched at start
- we  out  1  capture RAM write enable (combinational)
- waddr  out  ADDR_W  capture RAM write address (registered)
- armed  out  1  pre-trigger region full, triggers accepted
- triggered  out  1  trigger accepted, sticky until clr_done
- capture_done  out  1  capture complete, sticky until clr_done
- trig_addr  out  ADDR_W  waddr value in the trigger-accept cycle

## Operation
- States: IDLE, ARMING, WAIT_TRIG, POST, DONE.
- trig_hit = (trig_src[0] & UARTtrig) | (trig_src[1] & ext_trig).
- we = smpl_en & state ∈ {ARMING, WAIT_TRIG, POST}. waddr increments after every write, wraps ENTRIES-1 → 0.
- IDLE: on start, latch tp = trig_pos, clamped to range 1..ENTRIES-1 (0 → 1, ≥ENTRIES → ENTRIES-1). Clear waddr and counters. Go to ARMING.
- ARMING: pre_cnt counts writes. Once pre_cnt reaches ENTRIES-tp (including the current write), go to WAIT_TRIG. trig_hit is ignored.
- WAIT_TRIG: armed=1. On trig_hit:
  - trig_addr <= waddr; triggered <= 1.
  - A write in that same cycle is post-sample #1.
  - If tp==1 and smpl_en, go to DONE. Otherwise go to POST with post_cnt = smpl_en.
- POST: post_cnt counts writes. The write that makes post_cnt==tp moves to DONE. trig_hit is ignored.
- DONE: capture_done=1, we=0, waddr frozen, start ignored. clr_done → IDLE and clears armed/triggered/capture_done. trig_addr and waddr hold until the next start.
- start outside IDLE is ignored. clr_done outside DONE is ignored. clr_done and start in the same cycle in DONE: clr wins, start is dropped.
- Counter widths: pre_cnt and post_cnt are ADDR_W+1 bits, with no overflow within legal tp.

## Timing
- Reset value of every output: 0 (trig_addr, waddr, armed, triggered, capture_done). State is IDLE.
- Reset mid-capture aborts immediately; no partial done.
- start at cycle N → state ARMING at N+1. The first possible write is at N+1.
- armed rises the cycle after the final pre-trigger write.
- trig_hit at cycle N in WAIT_TRIG → triggered=1 at N+1, trig_addr valid at N+1.
- capture_done rises the cycle after the tp-th post-trigger write.
- we has zero latency from smpl_en.
- All state, counters, and flags are async reset; no other resets.

## Structure
- Package trig_pkg holds:
  - the cap_state_t enum
  - the ENTRIES default
  - trig_src bit-index localparams (TRIG_UART=0, TRIG_EXT=1)
- Sub-module cap_addr_cnt: modulo-ENTRIES write-address counter with clear, inc, and wrap. Used for waddr.
- Pre/post counters and FSM stay in trig_capture.

## Test plan
- ENTRIES=384, start with trig_pos=100, smpl_en always high:
  - armed rises after exactly 284 writes.
  - UARTtrig (src=01) one cycle later → trig_addr=284.
  - capture_done one cycle after the 100th post write, with waddr=0 (wrapped).
- UARTtrig pulsed during ARMING, and ext_trig with trig_src=01 during WAIT_TRIG → no trigger. A later UARTtrig is accepted.
- smpl_en every 4th cycle, trig_pos=1:
  - trig_hit coinciding with smpl_en → DONE next cycle after one write.
  - trig_hit without smpl_en → POST, then done after the next strobe.
- In DONE: start alone ignored; clr_done+start together → IDLE, flags 0, no capture started. A later start works.
- rst_n asserted mid-POST → all outputs 0 asynchronously, we=0.
- trig_pos=0 → behaves as 1. trig_pos=384 → behaves as 383 (armed after 1 write).
